// File: rtl/seq_signed_div_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and the counter-width helper.
package seq_signed_div_pkg;

    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_signed_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder and subtract the divisor if it fits.
module seq_signed_div_step #(
    parameter int N = 8
) (
    input  logic [N:0] rem,
    input  logic       dbit,
    input  logic [N:0] div,
    output logic [N:0] rem_nxt,
    output logic       qbit
);

    localparam int RW = N + 1;

    // One extra bit so the shifted remainder can never wrap before the compare.
    logic [N+1:0] shifted;

    always_comb begin
        shifted = {rem, dbit};
        qbit    = (shifted >= {1'b0, div});
        rem_nxt = qbit ? RW'(shifted - {1'b0, div}) : shifted[N:0];
    end

endmodule

// File: rtl/seq_signed_div.sv
// Sequential signed divider P(2N) / B(N) -> Q(N), R(N) with START/BUSY/DONE handshake.
// Define DIV_OVF_DETECT_EN to enable the quotient range pre-check and early finish.
module seq_signed_div
    import seq_signed_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           ovf
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [N:0]       rem_reg;
    logic [N-1:0]     lo_reg;
    logic [N:0]       div_reg;
    logic [N-1:0]     plo_reg;
    logic             sp_reg, sq_reg, bz_reg, rng_ovf_reg;
    logic             busy_reg, done_reg, ovf_reg;
    logic [N-1:0]     q_reg, r_reg;

    logic [2*N-1:0]   p_mag;
    logic [N:0]       b_ext, b_mag;
    logic             b_zero, pre_ovf;
    logic [N:0]       rem_nxt;
    logic             qbit;

`ifdef DIV_OVF_DETECT_EN
    logic [2*N:0]     lim_pos, lim_neg;
`endif

    // Magnitudes: a 2N-bit unsigned |P| already covers -2^(2N-1).
    always_comb begin
        p_mag   = p[2*N-1] ? (~p + 1'b1) : p;
        b_ext   = {b[N-1], b};
        b_mag   = b[N-1] ? (~b_ext + 1'b1) : b_ext;
        b_zero  = (b == '0);
        pre_ovf = 1'b0;
`ifdef DIV_OVF_DETECT_EN
        // |q| > 2^(N-1)-1 (positive) or |q| > 2^(N-1) (negative), without dividing.
        lim_pos = {1'b0, b_mag, {(N-1){1'b0}}};
        lim_neg = lim_pos + {{N{1'b0}}, b_mag};
        pre_ovf = b_zero ||
                  ((p[2*N-1] ^ b[N-1]) ? ({1'b0, p_mag} >= lim_neg)
                                       : ({1'b0, p_mag} >= lim_pos));
`endif
    end

    seq_signed_div_step #(.N(N)) u_step (
        .rem     (rem_reg),
        .dbit    (lo_reg[N-1]),
        .div     (div_reg),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = pre_ovf ? ST_FIN : ST_CALC;
            ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            lo_reg      <= '0;
            div_reg     <= '0;
            plo_reg     <= '0;
            sp_reg      <= 1'b0;
            sq_reg      <= 1'b0;
            bz_reg      <= 1'b0;
            rng_ovf_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            q_reg       <= '0;
            r_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // Upper half of |P| preloads the partial remainder;
                        // the lower half shifts out while quotient bits shift in.
                        rem_reg     <= {1'b0, p_mag[2*N-1:N]};
                        lo_reg      <= p_mag[N-1:0];
                        div_reg     <= b_mag;
                        plo_reg     <= p[N-1:0];
                        sp_reg      <= p[2*N-1];
                        sq_reg      <= p[2*N-1] ^ b[N-1];
                        bz_reg      <= b_zero;
                        rng_ovf_reg <= pre_ovf;
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_CALC: begin
                    rem_reg <= rem_nxt;
                    lo_reg  <= {lo_reg[N-2:0], qbit};
                    cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
                end
                ST_FIN: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    ovf_reg  <= bz_reg | rng_ovf_reg;
                    if (bz_reg) begin
                        q_reg <= '1;
                        r_reg <= plo_reg;
                    end else if (rng_ovf_reg) begin
                        q_reg <= sq_reg ? Q_MIN : Q_MAX;
                        r_reg <= '0;
                    end else begin
                        q_reg <= sq_reg ? (~lo_reg + 1'b1) : lo_reg;
                        r_reg <= sp_reg ? (~rem_reg[N-1:0] + 1'b1) : rem_reg[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign q    = q_reg;
    assign r    = r_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_signed_div.sv
// Bench for seq_signed_div: directed vectors, a round-trip sweep, and a
// compare process that checks every DONE against a $signed '/' '%' model.
module tb_seq_signed_div;
    import seq_signed_div_pkg::*;

    localparam int N   = DIV_N;
    localparam int LAT = N + 2;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*N-1:0] p = '0;
    logic [N-1:0]   b = '0;
    logic           busy, done, ovf;
    logic [N-1:0]   q, r;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t cmp_e;
    logic [N-1:0] got_q, got_r;
    logic         got_ovf;

    seq_signed_div #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .p     (p),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Reference: Verilog signed '/' and '%' on the full-precision values.
    function automatic exp_t model(input logic [2*N-1:0] pv, input logic [N-1:0] bv);
        exp_t e;
        int   pi, bi, qi, ri;
        pi = int'($signed(pv));
        bi = int'($signed(bv));
        if (bi == 0) begin
            e.q   = '1;
            e.r   = pv[N-1:0];
            e.ovf = 1'b1;
            return e;
        end
        qi = pi / bi;
        ri = pi % bi;
`ifdef DIV_OVF_DETECT_EN
        if (qi > (1 << (N-1)) - 1 || qi < -(1 << (N-1))) begin
            e.q   = (qi > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
            e.r   = '0;
            e.ovf = 1'b1;
            return e;
        end
`endif
        e.q   = qi[N-1:0];
        e.r   = ri[N-1:0];
        e.ovf = 1'b0;
        return e;
    endfunction

    function automatic int exp_lat(input logic [2*N-1:0] pv, input logic [N-1:0] bv);
`ifdef DIV_OVF_DETECT_EN
        exp_t e;
        e = model(pv, bv);
        if (e.ovf) return 2;
`endif
        return LAT;
    endfunction

    // Compare process: every DONE pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 required done=0 (no request outstanding)");
            end else begin
                cmp_e = exp_q.pop_front();
                check("model_q", {24'd0, q}, {24'd0, cmp_e.q});
                check("model_r", {24'd0, r}, {24'd0, cmp_e.r});
                check("model_ovf", {31'd0, ovf}, {31'd0, cmp_e.ovf});
            end
        end
    end

    // Issue one operation at a negedge and wait (bounded) for its DONE.
    task automatic run_op(input string tag, input logic [2*N-1:0] pv, input logic [N-1:0] bv,
                          input bit glitch, input bit verbose);
        int cyc;
        int lat;
        lat   = exp_lat(pv, bv);
        p     = pv;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(model(pv, bv));
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        p = '0;
        b = '0;
        while (!done && cyc < 4 * LAT) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = glitch && (cyc == 3);
            p = start ? 16'h0100 : '0;
            b = start ? 8'h01 : '0;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, lat);
        got_q   = q;
        got_r   = r;
        got_ovf = ovf;
        if (verbose)
            $display("%s: P=%h B=%h -> Q=%h R=%h OVF=%b cycles=%0d", tag, pv, bv, got_q, got_r, got_ovf, cyc);
    endtask

    initial begin
        int ks[$];
        int js[$];
        logic [2*N-1:0] prod;

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_q", {24'd0, q}, 0);
        check("reset_r", {24'd0, r}, 0);
        check("reset_ovf", {31'd0, ovf}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("t1", 16'h0C00, 8'h20, 1'b0, 1'b1);
        check("t1_q", {24'd0, got_q}, 32'h60);
        check("t1_r", {24'd0, got_r}, 32'h00);
        check("t1_ovf", {31'd0, got_ovf}, 0);

        run_op("t2a", 16'hFF9C, 8'h07, 1'b0, 1'b1);
        check("t2a_q", {24'd0, got_q}, 32'hF2);
        check("t2a_r", {24'd0, got_r}, 32'hFE);
        run_op("t2b", 16'h0064, 8'hF9, 1'b0, 1'b1);
        check("t2b_q", {24'd0, got_q}, 32'hF2);
        check("t2b_r", {24'd0, got_r}, 32'h02);

        run_op("glitch", 16'h0C00, 8'h20, 1'b1, 1'b1);
        check("glitch_q", {24'd0, got_q}, 32'h60);

        run_op("t4", 16'h1234, 8'h00, 1'b0, 1'b1);
        check("t4_q", {24'd0, got_q}, 32'hFF);
        check("t4_r", {24'd0, got_r}, 32'h34);
        check("t4_ovf", {31'd0, got_ovf}, 1);

        // Abort an operation mid-CALC with reset; outputs must clear immediately.
        p = 16'h0C00;
        b = 8'h20;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_q", {24'd0, q}, 0);
        check("abort_r", {24'd0, r}, 0);
        check("abort_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset mid-CALC: outputs cleared");

        run_op("after_rst", 16'hFF9C, 8'h07, 1'b0, 1'b1);
        check("after_rst_q", {24'd0, got_q}, 32'hF2);

`ifdef DIV_OVF_DETECT_EN
        run_op("t5a", 16'h4000, 8'h01, 1'b0, 1'b1);
        check("t5a_q", {24'd0, got_q}, 32'h7F);
        check("t5a_r", {24'd0, got_r}, 32'h00);
        check("t5a_ovf", {31'd0, got_ovf}, 1);
        run_op("t5b", 16'h8000, 8'hFF, 1'b0, 1'b1);
        check("t5b_q", {24'd0, got_q}, 32'h7F);
`endif

        // Round trip on a strided grid plus the sign/boundary corners.
        for (int k = -128; k <= 127; k += 15) ks.push_back(k);
        ks.push_back(0);
        ks.push_back(1);
        ks.push_back(-1);
        for (int j = -128; j <= 127; j += 5) js.push_back(j);
        js.push_back(1);
        js.push_back(-1);
        foreach (ks[ki]) begin
            foreach (js[ji]) begin
                int kv, jv, pr;
                logic [N-1:0] bj, kq;
                kv   = ks[ki];
                jv   = js[ji];
                pr   = kv * jv;
                prod = pr[2*N-1:0];
                bj   = jv[N-1:0];
                kq   = kv[N-1:0];
                run_op("rt", prod, bj, 1'b0, 1'b1);
                check("rt_q", {24'd0, got_q}, {24'd0, kq});
                check("rt_r", {24'd0, got_r}, 0);
            end
        end

        repeat (3 * LAT) @(negedge clk);
        check("outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
